// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done operand and result bundle of the serial subtractor.
// The master side issues operands; the slave side is the subtractor.
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             b_out;

    modport master (
        output start, a, b, b_in,
        input  busy, done, d, b_out
    );

    modport slave (
        input  start, a, b, b_in,
        output busy, done, d, b_out
    );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - b_in, LSB first, one bit per clock
// through a single full-subtractor cell and a borrow flip-flop.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    serial_subtractor_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_reg;
    logic             brw;
    logic             b_out_reg;
    logic             accept;
    logic             last_bit;
    logic             diff_bit;
    logic             brw_next;

    // Operands are only taken when no operation is in flight.
    assign accept   = bus.start && (state == S_IDLE || state == S_DONE);
    assign last_bit = (count == CW'(WIDTH - 1));

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (diff_bit),
        .bout (brw_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state decode; DONE with start held goes straight back to RUN.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            S_IDLE:  if (bus.start) state_next = S_RUN;
            S_RUN:   if (last_bit) state_next = S_DONE;
            S_DONE:  state_next = bus.start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: load on accept, then shift one bit per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sr      <= '0;
            b_sr      <= '0;
            d_reg     <= '0;
            brw       <= 1'b0;
            b_out_reg <= 1'b0;
            count     <= '0;
        end else if (accept) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            brw   <= bus.b_in;
            d_reg <= '0;
            count <= '0;
        end else if (state == S_RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            brw   <= brw_next;
            // Difference enters at the MSB so bit 0 lands at d[0] after WIDTH shifts.
            d_reg <= {diff_bit, d_reg[WIDTH-1:1]};
            count <= count + CW'(1);
            if (last_bit) b_out_reg <= brw_next;
        end
    end

    assign bus.busy  = (state == S_RUN);
    assign bus.done  = (state == S_DONE);
    assign bus.d     = d_reg;
    assign bus.b_out = b_out_reg;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor: computes D = A − B − b_in, LSB first, one bit per clock through a single full-subtractor cell plus a borrow flip-flop.
- It is the inverse-operation, sequential counterpart to the team's combinational ripple-carry adder.
- Operands are loaded with a start/busy/done handshake.
- Results are directly comparable against the ripple adder using two's-complement identities (A − B − b_in = A + ~B + ~b_in).

Parameters:
- WIDTH, 4, operand and result width in bits (≥ 2).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request: load operands and begin (sampled only when idle or done).
- a  input  WIDTH  minuend, captured on accepted start.
- b  input  WIDTH  subtrahend, captured on accepted start.
- b_in  input  1  borrow-in, captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse: d/b_out final.
- d  output  WIDTH  difference register (valid when done=1 and afterwards until next accepted start).
- b_out  output  1  final borrow-out (1 = A < B + b_in unsigned).

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (ports clk, reset).
- States:
  - IDLE: waiting for start.
  - RUN: bit-processing.
  - DONE: one cycle, done=1.
- Reset (sampled high at an edge): state=IDLE, busy=0, done=0, d=0, b_out=0, bit counter=0, borrow FF=0, operand shift regs=0. Reset overrides everything, including mid-RUN; the in-flight operation is discarded with no done pulse.
- Accept:
  - Edge E0 with start=1 and state ∈ {IDLE, DONE}: latch a, b into shift regs, borrow FF ← b_in, counter ← 0, d ← 0, state → RUN, busy=1.
  - start in RUN is ignored; operands are not re-sampled.
- RUN, edges E1..E_WIDTH, one bit i per edge:
  - diff = a_i ^ b_i ^ brw.
  - brw' = (~a_i & b_i) | (~(a_i ^ b_i) & brw).
  - diff shifts into d from MSB side (after WIDTH shifts d[0] holds bit 0).
  - Operand regs shift right; counter increments.
- At E_WIDTH:
  - Final bit processed; b_out ← brw'.
  - state → DONE; busy=0; done=1 during the following cycle.
- Latency: done asserted exactly WIDTH cycles after the accepting edge; with WIDTH=4, accept at E0 gives done high between E4 and E5.
- DONE, next edge:
  - start=1 → accept (back-to-back, no idle bubble), done=0.
  - Otherwise → IDLE, done=0.
  - d and b_out hold their values in IDLE.
- Intermediate d during RUN is partial and not valid.
- Arithmetic:
  - Modulo 2^WIDTH; no saturation.
  - b_out is unsigned borrow; signed overflow is not reported.
- Counter width: $clog2(WIDTH)+1; wrap is impossible because exit occurs at count WIDTH−1.
- busy and done are never high simultaneously.

Decomposition:
- Shared include (subtractor_defs.vh): state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2; default WIDTH=4.
- One natural sub-module: full_subtractor (1-bit: a, b, bin → d, bout), instantiated once in the datapath.
- FSM, counter and shift registers stay in serial_subtractor.

Test Plan:
- a=4'b0111, b=4'b0010, b_in=0, start pulse → done exactly 4 cycles after accept; d=4'b0101, b_out=0; busy high exactly 4 cycles.
- a=4'b0010, b=4'b0111, b_in=0 → d=4'b1011, b_out=1.
- a=4'b0000, b=4'b0000, b_in=1 → d=4'b1111, b_out=1; a=4'b1111, b=4'b1111, b_in=1 → d=4'b1111, b_out=1.
- Hold start=1 continuously with changing a/b during RUN:
  - mid-RUN values are ignored.
  - Operation 2 is accepted on the DONE edge with no gap.
  - Results match the operands captured at each accept.
- reset pulsed at E2 of an operation → next cycle busy=0, done=0, d=0, b_out=0, state IDLE; no done pulse ever appears for that operation.
- Exhaustive: all 512 {a, b, b_in} combinations for WIDTH=4, sequential back-to-back → each {b_out, d} equals ({1'b0,a} − {1'b0,b} − b_in) mod 32 reported as borrow/difference; zero mismatches.
